mult_div_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core, replacing the single-cycle HI/LO result path of the EX stage. It supports `MULT`, `MULTU`, `DIV` and `DIVU`. Width is set by a parameter. The unit asserts `busy` so that the hazard unit stalls any instruction that reads or writes HI/LO, or that issues a new multiply/divide, while an operation is in flight.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_div_step.sv | 28 ++
 rtl/mult_div_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and op encodings for the iterative multiply/divide unit.
// The op encodings are also decoded by the control unit.
package mdu_pkg;

  localparam logic [1:0] OPC_MULT  = 2'd0;
  localparam logic [1:0] OPC_MULTU = 2'd1;
  localparam logic [1:0] OPC_DIV   = 2'd2;
  localparam logic [1:0] OPC_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MULT  = OPC_MULT,
    MULTU = OPC_MULTU,
    DIV   = OPC_DIV,
    DIVU  = OPC_DIVU
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } mdu_state_t;

  // True for the two divide operations.
  function automatic logic is_div(input mdu_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // True for the two signed operations.
  function automatic logic is_signed_op(input mdu_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and keep the trial difference when it does not go negative.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W:0] rem_shift;
  logic [W:0] trial;

  // Trial subtraction on W+1 bits; quotient bit set when it does not underflow.
  always_comb begin
    rem_shift = {rem_i, bit_i};
    trial     = rem_shift - {1'b0, divisor_i};
    q_o       = (rem_shift >= {1'b0, divisor_i});
    if (q_o) begin
      rem_o = trial;
    end else begin
      rem_o = rem_shift;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional build macro MDU_EARLY_TERM_EN: multiply leaves RUN as soon as the
// remaining multiplier bits are zero (divide timing is unaffected).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  hi_wr,
  input  logic                  lo_wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mdu_state_t     state_q, state_d;
  mdu_op_t        op_q, op_d;
  logic [2*W-1:0] acc_q, acc_d;        // product accumulator / partial remainder
  logic [2*W-1:0] mcand_q, mcand_d;    // shifting multiplicand / divisor
  logic [W-1:0]   mplier_q, mplier_d;  // multiplier / dividend-then-quotient
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rsign_q, rsign_d;
  logic           remsign_q, remsign_d;
  logic           dz_q, dz_d;
  logic [W-1:0]   a_orig_q, a_orig_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  mdu_op_t        op_in;
  logic           in_signed;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     step_rem;
  logic           step_q;
  logic           last_iter;
  logic [2*W-1:0] prod;

  mdu_div_step #(.W(W)) u_div_step (
    .rem_i     (acc_q[W-1:0]),
    .bit_i     (mplier_q[W-1]),
    .divisor_i (mcand_q[W-1:0]),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // Operand magnitudes: signed ops work on |a| and |b| as unsigned values.
  always_comb begin
    op_in     = mdu_op_t'(op);
    in_signed = is_signed_op(op_in);
    if (in_signed && a[W-1]) begin
      a_mag = -a;
    end else begin
      a_mag = a;
    end
    if (in_signed && b[W-1]) begin
      b_mag = -b;
    end else begin
      b_mag = b;
    end
  end

  // Next-state, iteration datapath and HI/LO update.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    rsign_d   = rsign_q;
    remsign_d = remsign_q;
    dz_d      = dz_q;
    a_orig_d  = a_orig_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    last_iter = 1'b0;
    prod      = acc_q;
    case (state_q)
      IDLE: begin
        if (hi_wr) begin
          hi_d = wr_data;
        end else begin
          hi_d = hi_q;
        end
        if (lo_wr) begin
          lo_d = wr_data;
        end else begin
          lo_d = lo_q;
        end
        if (start) begin
          op_d = op_in;
          if (is_div(op_in)) begin
            mcand_d  = {{W{1'b0}}, b_mag};
            mplier_d = a_mag;
          end else begin
            mcand_d  = {{W{1'b0}}, a_mag};
            mplier_d = b_mag;
          end
          acc_d     = {(2*W){1'b0}};
          cnt_d     = {CW{1'b0}};
          rsign_d   = in_signed & (a[W-1] ^ b[W-1]);
          remsign_d = in_signed & a[W-1];
          dz_d      = is_div(op_in) & (b == {W{1'b0}});
          a_orig_d  = a;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (is_div(op_q)) begin
          acc_d    = {{(W-1){1'b0}}, step_rem};
          mplier_d = {mplier_q[W-2:0], step_q};
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = {mcand_q[2*W-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[W-1:1]};
        end
        cnt_d = cnt_q + CNT_ONE;
`ifdef MDU_EARLY_TERM_EN
        last_iter = (cnt_q == CNT_LAST) ||
                    (!is_div(op_q) && (mplier_q[W-1:1] == {(W-1){1'b0}}));
`else
        last_iter = (cnt_q == CNT_LAST);
`endif
        if (last_iter) begin
          state_d = FIXUP;
        end else begin
          state_d = RUN;
        end
      end
      FIXUP: begin
        if (is_div(op_q)) begin
          if (dz_q) begin
            lo_d = {W{1'b1}};
            hi_d = a_orig_q;
          end else begin
            lo_d = rsign_q ? -mplier_q : mplier_q;
            hi_d = remsign_q ? -(acc_q[W-1:0]) : acc_q[W-1:0];
          end
        end else begin
          prod = rsign_q ? -acc_q : acc_q;
          hi_d = prod[2*W-1:W];
          lo_d = prod[W-1:0];
        end
        done_d  = 1'b1;
        dbz_d   = dz_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, datapath and architectural registers; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= MULT;
      acc_q     <= {(2*W){1'b0}};
      mcand_q   <= {(2*W){1'b0}};
      mplier_q  <= {W{1'b0}};
      cnt_q     <= {CW{1'b0}};
      rsign_q   <= 1'b0;
      remsign_q <= 1'b0;
      dz_q      <= 1'b0;
      a_orig_q  <= {W{1'b0}};
      hi_q      <= {W{1'b0}};
      lo_q      <= {W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      rsign_q   <= rsign_d;
      remsign_q <= remsign_d;
      dz_q      <= dz_d;
      a_orig_q  <= a_orig_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations. Honours MDU_EARLY_TERM_EN.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0, b = '0, wr_data = '0;
  logic         hi_wr = 1'b0, lo_wr = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {div_by_zero, HI, LO} from plain arithmetic.
  function automatic logic [2*W:0] ref_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int          sx, sy;
    longint      sp;
    logic [63:0] up;
    logic [W-1:0] ones;
    sx = x; sy = y; ones = '1;
    case (o)
      2'd0: begin sp = longint'(sx) * longint'(sy); return {1'b0, sp}; end
      2'd1: begin up = {32'd0, x} * {32'd0, y}; return {1'b0, up}; end
      2'd2: begin
        if (y == 0) return {1'b1, x, ones};
        else if (x == 32'h8000_0000 && y == ones) return {1'b0, 32'd0, 32'h8000_0000};
        else return {1'b0, 32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 0) return {1'b1, x, ones};
        else return {1'b0, x % y, x / y};
      end
    endcase
  endfunction

`ifdef MDU_EARLY_TERM_EN
  // Multiply latency with early exit: max(1, msb_index(|b|)+1) + 1.
  function automatic int early_lat(input logic [1:0] o, input logic [W-1:0] y);
    logic [W-1:0] mag;
    int run;
    mag = (o == 2'd0 && y[W-1]) ? -y : y;
    run = 1;
    for (int i = 0; i < W; i++) if (mag[i]) run = i + 1;
    return run + 1;
  endfunction
`endif

  // Reference model: cycles remaining until the result lands, pending result.
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dz = 1'b0;
  int           m_rem = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; m_done = 1'b1; m_dbz = p_dz;
        end
      end else begin
        if (hi_wr) m_hi = wr_data;
        if (lo_wr) m_lo = wr_data;
        if (start) begin
          {p_dz, p_hi, p_lo} = ref_result(op, a, b);
          m_rem = W + 1;
`ifdef MDU_EARLY_TERM_EN
          if (!op[1]) m_rem = early_lat(op, b);
`endif
          m_busy = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("div_by_zero", div_by_zero, m_dbz);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // Launch one op, wait (bounded) for done, check literal results and latency.
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz, input int elat);
    int   k;
    logic all_busy;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 0; all_busy = 1'b1;
    while (!done && k < 100) begin
      all_busy &= busy;
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, k, elat);
    check({name, " busy throughout"}, all_busy, 1'b1);
    check({name, " HI"}, hi, eh);
    check({name, " LO"}, lo, el);
    check({name, " div_by_zero"}, div_by_zero, edz);
    @(negedge clk);
    check({name, " done one cycle"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset HI", hi, 32'h0);
    check("reset LO", lo, 32'h0);

    run_op("MULTU max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
`ifdef MDU_EARLY_TERM_EN
    run_op("MULT -3*7", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 4);
    run_op("MULTU 5*3", 2'd1, 32'd5, 32'd3, 32'h0, 32'd15, 1'b0, 3);
    run_op("MULT min*2", 2'd0, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0, 1'b0, 3);
`else
    run_op("MULT -3*7", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    run_op("MULTU 5*3", 2'd1, 32'd5, 32'd3, 32'h0, 32'd15, 1'b0, 33);
    run_op("MULT min*2", 2'd0, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
`endif
    run_op("DIV -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("DIV 7/-2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("DIVU 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    run_op("DIVU 100/0", 2'd3, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1, 33);
    run_op("DIV -5/0", 2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 33);
    run_op("DIV min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);

    // MTHI/MTLO together with start in IDLE: writes land, result overwrites later.
    @(negedge clk);
    op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h0000_ABCD;
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    check("MT with start HI", hi, 32'h0000_ABCD);
    check("MT with start LO", lo, 32'h0000_ABCD);
    k = 0;
    while (!done && k < 100) begin @(negedge clk); k++; end
    check("MT with start latency", k, 33);
    check("MT with start result LO", lo, 32'd14);
    // New start accepted in the cycle done is high.
    op = 2'd1; a = 32'd6; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 0;
    while (!done && k < 100) begin @(negedge clk); k++; end
`ifdef MDU_EARLY_TERM_EN
    check("back-to-back latency", k, 4);
`else
    check("back-to-back latency", k, 33);
`endif
    check("back-to-back LO", lo, 32'd42);
    check("back-to-back HI", hi, 32'd0);

    // start and MTHI during an operation are ignored.
    @(negedge clk);
    op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 0;
    while (!done && k < 100) begin
      if (k == 5) begin
        op = 2'd1; a = 32'd3; b = 32'd3; start = 1'b1; hi_wr = 1'b1; wr_data = 32'h0000_DEAD;
      end else begin
        start = 1'b0; hi_wr = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0; hi_wr = 1'b0;
    check("ignored start latency", k, 33);
    check("ignored start HI", hi, 32'd2);
    check("ignored start LO", lo, 32'd14);
    @(negedge clk);
    check("ignored start stays idle", busy, 1'b0);

    // Asynchronous reset mid-RUN, then MTLO in IDLE.
    op = 2'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset busy", busy, 1'b0);
    check("async reset HI", hi, 32'h0);
    check("async reset LO", lo, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    lo_wr = 1'b1; wr_data = 32'h0000_1234;
    @(negedge clk);
    lo_wr = 1'b0;
    check("MTLO after reset LO", lo, 32'h0000_1234);
    check("MTLO after reset HI", hi, 32'h0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
